control_sequencer: RTL and testbench

//  Sequencing control unit for the 8-bit single-cycle CPU datapath (cd). Decodes opcode, drives all datapath selects/enables.

---
 rtl/control_sequencer_pkg.sv | 24 ++
 rtl/control_sequencer_stack_guard.sv | 37 +++
 rtl/control_sequencer.sv | 144 ++++++++++++++
 tb/tb_control_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: FSM state codes, opcodes and writeback/output select encodings.
package control_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_IN  = 2'd1,
      ST_WAIT_OUT = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   // Exact opcodes; the ALU/LI/LD/ST/IN/OUT groups are decoded on their prefix bits.
   localparam logic [5:0] OP_J    = 6'b010100;
   localparam logic [5:0] OP_JZ   = 6'b010101;
   localparam logic [5:0] OP_JNZ  = 6'b010110;
   localparam logic [5:0] OP_CALL = 6'b010111;
   localparam logic [5:0] OP_RET  = 6'b011000;
   localparam logic [5:0] OP_HALT = 6'b011111;

   localparam logic [1:0] SINM_ALU = 2'b00;
   localparam logic [1:0] SINM_IMM = 2'b01;
   localparam logic [1:0] SINM_MEM = 2'b10;
   localparam logic [1:0] SINM_IN  = 2'b11;

endpackage

// File: rtl/control_sequencer_stack_guard.sv
// Return-stack depth tracker: counts 0..STACK_DEPTH and flags full/empty so the sequencer can trap.
module control_sequencer_stack_guard #(
   parameter int STACK_DEPTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o
);

   localparam int DW = $clog2(STACK_DEPTH + 1);

   logic [DW-1:0] depth_q, depth_d;

   always_comb begin
      depth_d = depth_q;
      if (push_i && !pop_i) begin
         depth_d = depth_q + 1'b1;
      end else if (pop_i && !push_i) begin
         depth_d = depth_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   assign full_o  = (depth_q == DW'(STACK_DEPTH));
   assign empty_o = (depth_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// Opcode decoder plus RUN/WAIT_IN/WAIT_OUT/HALT sequencer for the 8-bit CPU datapath.
// Define CTRL_IO_TIMEOUT_EN to bound I/O waits at IO_TIMEOUT cycles (skip + fault instead of stalling forever).
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int STACK_DEPTH = 16,
   parameter int IO_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       z,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       in_ack,
   output logic       pc_we,
   output logic       s_inc,
   output logic       we3,
   output logic       wez,
   output logic       we4,
   output logic       we_out,
   output logic       pushsignal,
   output logic       popsignal,
   output logic       s_stack,
   output logic [1:0] s_inm,
   output logic [1:0] s_in,
   output logic [1:0] s_out,
   output logic [2:0] op_alu,
   output logic       halted,
   output logic       fault,
   output logic [1:0] dbg_state
);

   state_e state_q, state_d;
   logic   halted_q, halted_d, fault_q, fault_d;
   logic   we3_dec, wez_dec, we4_dec, we_out_dec;
   logic   is_in, is_out, is_call, is_ret, is_halt;
   logic   pc_we_ns, io_ok, in_ack_ns, push_ns, pop_ns, trap, tmo;
   logic   stk_full, stk_empty, timeout_hit, run_ok;

   always_comb begin
      we3_dec = 1'b0; wez_dec = 1'b0; we4_dec = 1'b0; we_out_dec = 1'b0;
      s_inc = 1'b1; s_stack = 1'b0; s_inm = SINM_ALU; s_in = 2'b00; s_out = 2'b00; op_alu = 3'b000;
      is_in = 1'b0; is_out = 1'b0; is_call = 1'b0; is_ret = 1'b0; is_halt = 1'b0;
      casez (opcode)
         6'b1?????: begin op_alu = opcode[4:2]; we3_dec = 1'b1; wez_dec = 1'b1; s_inm = SINM_ALU; end
         6'b0000??: begin s_inm = SINM_IMM; we3_dec = 1'b1; end
         6'b0001??: begin s_inm = SINM_MEM; we3_dec = 1'b1; end
         6'b0010??: we4_dec = 1'b1;
         6'b0011??: begin s_inm = SINM_IN; s_in = opcode[1:0]; we3_dec = 1'b1; is_in = 1'b1; end
         6'b01000?: begin s_out = {1'b0, opcode[0]}; we_out_dec = 1'b1; is_out = 1'b1; end
         OP_J:      s_inc = 1'b0;
         OP_JZ:     s_inc = ~z;
         OP_JNZ:    s_inc = z;
         OP_CALL:   begin s_inc = 1'b0; is_call = 1'b1; end
         OP_RET:    begin s_stack = 1'b1; is_ret = 1'b1; end
         OP_HALT:   is_halt = 1'b1;
         default:   ;
      endcase
   end

   // io_ok gates the register/output write of an IN/OUT: only on a completed handshake.
   always_comb begin
      state_d = state_q; pc_we_ns = 1'b1; io_ok = 1'b0; in_ack_ns = 1'b0;
      push_ns = 1'b0; pop_ns = 1'b0; trap = 1'b0; tmo = 1'b0;
      if (state_q == ST_HALT) begin
         pc_we_ns = 1'b0;
      end else if (is_in || is_out) begin
         if ((is_in && in_valid) || (is_out && out_ready)) begin
            io_ok = 1'b1; in_ack_ns = is_in; state_d = ST_RUN;
         end else if (timeout_hit) begin
            tmo = 1'b1; state_d = ST_RUN;
         end else begin
            pc_we_ns = 1'b0; state_d = is_in ? ST_WAIT_IN : ST_WAIT_OUT;
         end
      end else if (is_halt) begin
         pc_we_ns = 1'b0; state_d = ST_HALT;
      end else if ((is_call && stk_full) || (is_ret && stk_empty)) begin
         trap = 1'b1; pc_we_ns = 1'b0; state_d = ST_HALT;
      end else begin
         push_ns = is_call; pop_ns = is_ret; state_d = ST_RUN;
      end
      halted_d = halted_q | (state_d == ST_HALT);
      fault_d  = fault_q | trap | tmo;
   end

   always_comb begin
      run_ok     = ~reset && (state_q != ST_HALT);
      pc_we      = ~reset && pc_we_ns;
      we3        = run_ok && we3_dec && (!is_in || io_ok);
      wez        = run_ok && wez_dec;
      we4        = run_ok && we4_dec;
      we_out     = run_ok && we_out_dec && io_ok;
      in_ack     = run_ok && in_ack_ns;
      pushsignal = run_ok && push_ns;
      popsignal  = run_ok && pop_ns;
      halted     = halted_q;
      fault      = fault_q;
      dbg_state  = state_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

`ifdef CTRL_IO_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       in_wait;

   assign in_wait     = (state_q == ST_WAIT_IN) || (state_q == ST_WAIT_OUT);
   assign timeout_hit = in_wait && (cnt_q == 8'(IO_TIMEOUT - 1));
   assign cnt_d       = (in_wait && state_d != ST_RUN) ? cnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(IO_TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   control_sequencer_stack_guard #(.STACK_DEPTH(STACK_DEPTH)) u_stack_guard (
      .clk    (clk),
      .reset  (reset),
      .push_i (pushsignal),
      .pop_i  (popsignal),
      .full_o (stk_full),
      .empty_o(stk_empty)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: inputs change 1ns after posedge, outputs are checked at negedge.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       reset, z, in_valid, out_ready;
   logic [5:0] opcode;
   logic       in_ack, pc_we, s_inc, we3, wez, we4, we_out;
   logic       pushsignal, popsignal, s_stack, halted, fault;
   logic [1:0] s_inm, s_in, s_out, dbg_state;
   logic [2:0] op_alu;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];

   control_sequencer #(.STACK_DEPTH(16), .IO_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .in_valid(in_valid), .out_ready(out_ready),
      .in_ack(in_ack), .pc_we(pc_we), .s_inc(s_inc), .we3(we3), .wez(wez), .we4(we4), .we_out(we_out),
      .pushsignal(pushsignal), .popsignal(popsignal), .s_stack(s_stack), .s_inm(s_inm), .s_in(s_in),
      .s_out(s_out), .op_alu(op_alu), .halted(halted), .fault(fault), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 6'b100100; z = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      settle();
      checks++; if (pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we got=%b exp=0", pc_we); end
      checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%b exp=0", we3); end
      tick(); reset = 1'b0; opcode = 6'b011010;
      settle();
      checks++; if ({halted, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, fault}); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
   endtask

   task automatic test_decode();
      tick(); opcode = 6'b100100;
      settle();
      checks++; if ({we3, wez, op_alu, s_inm, pc_we} !== 8'b11_001_00_1) begin errors++; $display("FAIL alu_001 got=%b exp=11001001", {we3, wez, op_alu, s_inm, pc_we}); end
      tick(); opcode = 6'b111011;
      settle();
      checks++; if (op_alu !== 3'b110) begin errors++; $display("FAIL alu_110 got=%b exp=110", op_alu); end
      tick(); opcode = 6'b000010;
      settle();
      checks++; if ({s_inm, wez} !== 3'b01_0) begin errors++; $display("FAIL li got=%b exp=010", {s_inm, wez}); end
      tick(); opcode = 6'b000111;
      settle();
      checks++; if (s_inm !== 2'b10) begin errors++; $display("FAIL ld_sinm got=%b exp=10", s_inm); end
      tick(); opcode = 6'b001001;
      settle();
      checks++; if ({we4, we3, pc_we} !== 3'b101) begin errors++; $display("FAIL st got=%b exp=101", {we4, we3, pc_we}); end
      tick(); opcode = 6'b010001; out_ready = 1'b1;
      settle();
      checks++; if ({we_out, s_out, pc_we} !== 4'b1_01_1) begin errors++; $display("FAIL out_ready got=%b exp=1011", {we_out, s_out, pc_we}); end
      tick(); opcode = 6'b011010;
      settle();
      checks++; if ({we3, wez, we4, we_out, pushsignal, popsignal, s_inc, pc_we} !== 8'b00000011) begin errors++; $display("FAIL nop got=%b exp=00000011", {we3, wez, we4, we_out, pushsignal, popsignal, s_inc, pc_we}); end
   endtask

   task automatic test_in_wait();
      tick(); opcode = 6'b001101; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if ({pc_we, we3, in_ack} !== 3'b000) begin errors++; $display("FAIL in_stall%0d got=%b exp=000", i, {pc_we, we3, in_ack}); end
         tick();
         checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL in_wait_state%0d got=%0d exp=1", i, dbg_state); end
      end
      in_valid = 1'b1;
      settle();
      checks++; if ({we3, s_in, in_ack, pc_we, s_inm} !== 7'b1_01_1_1_11) begin errors++; $display("FAIL in_done got=%b exp=1011111", {we3, s_in, in_ack, pc_we, s_inm}); end
      tick(); opcode = 6'b011010;
      settle();
      checks++; if ({dbg_state, in_ack} !== 3'b000) begin errors++; $display("FAIL in_back_run got=%b exp=000", {dbg_state, in_ack}); end
   endtask

   task automatic test_jumps();
      logic [5:0] ops[5] = '{6'b010101, 6'b010101, 6'b010110, 6'b010110, 6'b010100};
      logic       zs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       exp[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         tick(); opcode = ops[i]; z = zs[i];
         settle();
         checks++; if ({s_inc, pc_we} !== {exp[i], 1'b1}) begin errors++; $display("FAIL jump%0d got=%b exp=%b1", i, {s_inc, pc_we}, exp[i]); end
      end
      z = 1'b0;
   endtask

   task automatic test_back_to_back();
      // expected {pc_we, we3, we4, we_out}
      logic [5:0] ops[6] = '{6'b101000, 6'b000001, 6'b001011, 6'b010000, 6'b010100, 6'b011100};
      logic [3:0] exp;
      exp_q = '{4'b1100, 4'b1100, 4'b1010, 4'b1001, 4'b1000, 4'b1000};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(); opcode = ops[i];
         settle();
         exp = exp_q.pop_front();
         checks++; if ({pc_we, we3, we4, we_out} !== exp) begin errors++; $display("FAIL b2b%0d got=%b exp=%b", i, {pc_we, we3, we4, we_out}, exp); end
      end
   endtask

   task automatic test_stack_overflow();
      tick(); do_reset(); opcode = 6'b010111;
      for (int i = 0; i < 16; i++) begin
         settle();
         checks++; if ({pushsignal, s_inc, pc_we} !== 3'b101) begin errors++; $display("FAIL call%0d got=%b exp=101", i, {pushsignal, s_inc, pc_we}); end
         tick();
      end
      settle();
      checks++; if ({pushsignal, pc_we} !== 2'b00) begin errors++; $display("FAIL call17 got=%b exp=00", {pushsignal, pc_we}); end
      tick(); opcode = 6'b100000;
      settle();
      checks++; if ({fault, halted, dbg_state} !== 4'b11_11) begin errors++; $display("FAIL ovf_trap got=%b exp=1111", {fault, halted, dbg_state}); end
      checks++; if ({pc_we, we3, wez} !== 3'b000) begin errors++; $display("FAIL ovf_frozen got=%b exp=000", {pc_we, we3, wez}); end
   endtask

   task automatic test_ret_underflow();
      tick(); do_reset(); opcode = 6'b010111;
      tick(); opcode = 6'b011000;
      settle();
      checks++; if ({popsignal, s_stack, pc_we} !== 3'b111) begin errors++; $display("FAIL ret_ok got=%b exp=111", {popsignal, s_stack, pc_we}); end
      tick();
      settle();
      checks++; if ({popsignal, pc_we} !== 2'b00) begin errors++; $display("FAIL ret_empty got=%b exp=00", {popsignal, pc_we}); end
      tick();
      checks++; if ({fault, halted, dbg_state} !== 4'b11_11) begin errors++; $display("FAIL unf_trap got=%b exp=1111", {fault, halted, dbg_state}); end
      do_reset(); opcode = 6'b011010;
      settle();
      checks++; if ({fault, halted, dbg_state, pc_we} !== 5'b00_00_1) begin errors++; $display("FAIL unf_reset got=%b exp=00001", {fault, halted, dbg_state, pc_we}); end
   endtask

   task automatic test_halt();
      tick(); opcode = 6'b011111;
      settle();
      checks++; if ({pc_we, halted} !== 2'b00) begin errors++; $display("FAIL halt_op got=%b exp=00", {pc_we, halted}); end
      tick(); opcode = 6'b001000;
      settle();
      checks++; if ({halted, fault, dbg_state, we4, pc_we} !== 6'b10_11_00) begin errors++; $display("FAIL halt_state got=%b exp=101100", {halted, fault, dbg_state, we4, pc_we}); end
   endtask

   task automatic test_reset_mid_wait();
      tick(); do_reset(); opcode = 6'b001110; in_valid = 1'b0;
      tick(); tick();
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL midwait_state got=%0d exp=1", dbg_state); end
      reset = 1'b1; in_valid = 1'b1;
      settle();
      checks++; if ({in_ack, we3, pc_we} !== 3'b000) begin errors++; $display("FAIL midwait_reset got=%b exp=000", {in_ack, we3, pc_we}); end
      tick(); reset = 1'b0; opcode = 6'b011010;
      settle();
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL midwait_run got=%0d exp=0", dbg_state); end
   endtask

`ifdef CTRL_IO_TIMEOUT_EN
   task automatic test_out_timeout();
      tick(); do_reset(); opcode = 6'b010000; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         checks++; if ({pc_we, we_out, fault} !== 3'b000) begin errors++; $display("FAIL tmo_stall%0d got=%b exp=000", i, {pc_we, we_out, fault}); end
         tick();
      end
      settle();
      checks++; if ({pc_we, we_out} !== 2'b10) begin errors++; $display("FAIL tmo_skip got=%b exp=10", {pc_we, we_out}); end
      tick(); opcode = 6'b011010;
      settle();
      checks++; if ({fault, halted, dbg_state} !== 4'b10_00) begin errors++; $display("FAIL tmo_fault got=%b exp=1000", {fault, halted, dbg_state}); end
   endtask
`else
   task automatic test_out_unbounded();
      tick(); do_reset(); opcode = 6'b010000; out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      settle();
      checks++; if ({pc_we, we_out, fault, dbg_state} !== 5'b000_10) begin errors++; $display("FAIL out_wait got=%b exp=00010", {pc_we, we_out, fault, dbg_state}); end
      tick(); out_ready = 1'b1;
      settle();
      checks++; if ({pc_we, we_out} !== 2'b11) begin errors++; $display("FAIL out_done got=%b exp=11", {pc_we, we_out}); end
   endtask
`endif

   initial begin
      test_reset();
      test_decode();
      test_in_wait();
      test_jumps();
      test_back_to_back();
      test_stack_overflow();
      test_ret_underflow();
      test_halt();
      test_reset_mid_wait();
`ifdef CTRL_IO_TIMEOUT_EN
      test_out_timeout();
`else
      test_out_unbounded();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
